// File: rtl/seq_timing_ctrl.sv
// Sequence counter / timing generator for the basic computer: SC, T0..T7 decode,
// and the S, IEN and R flip-flops. Define SEQ_SC_OVF_EN to build the sticky SC_OVF flag.
module seq_timing_ctrl #(
    parameter int SC_W     = 3,
    parameter int NUM_T    = 2 ** SC_W,
    parameter int INT_LAST = 2
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             START,
    input  logic             HALT,
    input  logic             SC_CLR,
    input  logic             ION,
    input  logic             IOF,
    input  logic             INT_REQ,
    output logic [SC_W-1:0]  t,
    output logic [NUM_T-1:0] T,
    output logic             S,
    output logic             IEN,
    output logic             R,
    output logic             SC_OVF
);

    localparam logic [SC_W-1:0] INT_LAST_T = SC_W'(INT_LAST);

    logic [SC_W-1:0] sc_q, sc_d;
    logic            s_q, s_d;
    logic            ien_q, ien_d;
    logic            r_q, r_d;
    logic            int_done;
    logic            clr_blocked;
    logic            sc_clr_ok;
    logic            r_set;

    // NOTE: every signal written here gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        s_d   = s_q;
        sc_d  = sc_q;
        ien_d = ien_q;
        r_d   = r_q;

        // The last interrupt-cycle step always completes; SC_CLR cannot cut it short.
        int_done    = s_q && r_q && (sc_q == INT_LAST_T);
        clr_blocked = r_q && (sc_q < INT_LAST_T);
        sc_clr_ok   = SC_CLR && !clr_blocked;
        r_set       = s_q && (sc_q > INT_LAST_T) && ien_q && INT_REQ;

        if (HALT) begin
            s_d = 1'b0;
        end else if (START) begin
            s_d = 1'b1;
        end

        if (!s_q) begin
            if (SC_CLR) begin
                sc_d = '0;
            end
        end else if (int_done) begin
            sc_d = '0;
        end else if (sc_clr_ok) begin
            sc_d = '0;
        end else begin
            sc_d = sc_q + 1'b1;
        end

        if (int_done) begin
            r_d = 1'b0;
        end else if (r_set) begin
            r_d = 1'b1;
        end

        if (int_done) begin
            ien_d = 1'b0;
        end else if (IOF) begin
            ien_d = 1'b0;
        end else if (ION) begin
            ien_d = 1'b1;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            sc_q  <= '0;
            s_q   <= 1'b0;
            ien_q <= 1'b0;
            r_q   <= 1'b0;
        end else begin
            sc_q  <= sc_d;
            s_q   <= s_d;
            ien_q <= ien_d;
            r_q   <= r_d;
        end
    end

    // Strobes are a pure decode of registered state: no extra cycle of latency.
    always_comb begin
        T = '0;
        if (s_q) begin
            T[sc_q] = 1'b1;
        end
    end

`ifdef SEQ_SC_OVF_EN
    logic ovf_q;
    logic sc_wrap;

    // Only a wrap by increment counts; any clear path to 0 is a legitimate end of sequence.
    assign sc_wrap = s_q && !int_done && !sc_clr_ok && (sc_q == '1);

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            ovf_q <= 1'b0;
        end else if (sc_wrap) begin
            ovf_q <= 1'b1;
        end
    end

    assign SC_OVF = ovf_q;
`else
    assign SC_OVF = 1'b0;
`endif

    assign t   = sc_q;
    assign S   = s_q;
    assign IEN = ien_q;
    assign R   = r_q;

endmodule

// File: tb/tb_seq_timing_ctrl.sv
// Directed bench for seq_timing_ctrl: inputs driven and outputs sampled on the falling edge.
module tb_seq_timing_ctrl;

    logic       CLK = 1'b0;
    logic       RST_N, START, HALT, SC_CLR, ION, IOF, INT_REQ;
    logic [2:0] t;
    logic [7:0] T;
    logic       S, IEN, R, SC_OVF;

    int checks   = 0;
    int failures = 0;

`ifdef SEQ_SC_OVF_EN
    localparam logic OVF_EXP = 1'b1;
`else
    localparam logic OVF_EXP = 1'b0;
`endif

    seq_timing_ctrl dut (
        .CLK    (CLK),
        .RST_N  (RST_N),
        .START  (START),
        .HALT   (HALT),
        .SC_CLR (SC_CLR),
        .ION    (ION),
        .IOF    (IOF),
        .INT_REQ(INT_REQ),
        .t      (t),
        .T      (T),
        .S      (S),
        .IEN    (IEN),
        .R      (R),
        .SC_OVF (SC_OVF)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    // Full state snapshot against hand-computed values.
    task automatic check_all(input string tag, input logic [2:0] e_t, input logic [7:0] e_T,
                             input logic e_s, input logic e_ien, input logic e_r);
        check({tag, ".t"}, 32'(t), 32'(e_t));
        check({tag, ".T"}, 32'(T), 32'(e_T));
        check({tag, ".S"}, 32'(S), 32'(e_s));
        check({tag, ".IEN"}, 32'(IEN), 32'(e_ien));
        check({tag, ".R"}, 32'(R), 32'(e_r));
    endtask

    task automatic step();
        @(posedge CLK);
        @(negedge CLK);
    endtask

    initial begin
        RST_N = 1'b0; START = 1'b0; HALT = 1'b0; SC_CLR = 1'b0;
        ION = 1'b0; IOF = 1'b0; INT_REQ = 1'b0;

        // Reset held for two clocks
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        check_all("reset", 3'd0, 8'h00, 1'b0, 1'b0, 1'b0);
        check("reset.ovf", 32'(SC_OVF), 32'(1'b0));

        // Release with START for one clock: S set, t still 0 on that edge
        RST_N = 1'b1; START = 1'b1;
        step();
        START = 1'b0;
        check_all("run0", 3'd0, 8'h01, 1'b1, 1'b0, 1'b0);
        step(); check_all("run1", 3'd1, 8'h02, 1'b1, 1'b0, 1'b0);
        step(); check_all("run2", 3'd2, 8'h04, 1'b1, 1'b0, 1'b0);
        step(); check_all("run3", 3'd3, 8'h08, 1'b1, 1'b0, 1'b0);

        // End of instruction at t=3
        SC_CLR = 1'b1;
        step();
        SC_CLR = 1'b0;
        check_all("eoi", 3'd0, 8'h01, 1'b1, 1'b0, 1'b0);

        // ION pulse, then count to t=4
        ION = 1'b1;
        step();
        ION = 1'b0;
        check_all("ion", 3'd1, 8'h02, 1'b1, 1'b1, 1'b0);
        step(); step(); step();
        check_all("t4", 3'd4, 8'h10, 1'b1, 1'b1, 1'b0);

        // Interrupt request at t=4 sets R
        INT_REQ = 1'b1;
        step();
        INT_REQ = 1'b0;
        check_all("rset", 3'd5, 8'h20, 1'b1, 1'b1, 1'b1);

        // SC_CLR at t=5 with R=1 enters the interrupt cycle
        SC_CLR = 1'b1;
        step();
        check_all("rt0", 3'd0, 8'h01, 1'b1, 1'b1, 1'b1);

        // SC_CLR during RT0 is ignored
        step();
        SC_CLR = 1'b0;
        check_all("rt1_clr_ignored", 3'd1, 8'h02, 1'b1, 1'b1, 1'b1);
        step();
        check_all("rt2", 3'd2, 8'h04, 1'b1, 1'b1, 1'b1);

        // ION at the RT2 edge loses to the interrupt-cycle clear
        ION = 1'b1;
        step();
        ION = 1'b0;
        check_all("rt_exit", 3'd0, 8'h01, 1'b1, 1'b0, 1'b0);

        // IOF beats ION
        ION = 1'b1; IOF = 1'b1;
        step();
        check_all("ion_iof", 3'd1, 8'h02, 1'b1, 1'b0, 1'b0);
        IOF = 1'b0;
        step();
        ION = 1'b0;
        check_all("ion_only", 3'd2, 8'h04, 1'b1, 1'b1, 1'b0);
        IOF = 1'b1;
        step();
        IOF = 1'b0;
        check_all("iof_only", 3'd3, 8'h08, 1'b1, 1'b0, 1'b0);
        ION = 1'b1;
        step();
        ION = 1'b0;
        check_all("ion_again", 3'd4, 8'h10, 1'b1, 1'b1, 1'b0);

        // START and HALT together: HALT wins; the edge itself still counts (S was 1)
        START = 1'b1; HALT = 1'b1;
        step();
        START = 1'b0; HALT = 1'b0;
        check_all("halt", 3'd5, 8'h00, 1'b1 ^ 1'b1, 1'b1, 1'b0);
        step();
        check_all("halt_frozen", 3'd5, 8'h00, 1'b0, 1'b1, 1'b0);

        // Restart: t holds on the START edge
        START = 1'b1;
        step();
        START = 1'b0;
        check_all("restart", 3'd5, 8'h20, 1'b1, 1'b1, 1'b0);

        // R set and SC_CLR together: both take effect
        INT_REQ = 1'b1; SC_CLR = 1'b1;
        step();
        INT_REQ = 1'b0; SC_CLR = 1'b0;
        check_all("rset_clr", 3'd0, 8'h01, 1'b1, 1'b1, 1'b1);
        step();
        check_all("rt1", 3'd1, 8'h02, 1'b1, 1'b1, 1'b1);

        // Async reset between edges
        #2 RST_N = 1'b0;
        #1;
        check_all("async_rst", 3'd0, 8'h00, 1'b0, 1'b0, 1'b0);
        @(negedge CLK);
        RST_N = 1'b1;

        // Overflow: eight increments without SC_CLR
        START = 1'b1;
        step();
        START = 1'b0;
        check_all("ovf_start", 3'd0, 8'h01, 1'b1, 1'b0, 1'b0);
        repeat (7) step();
        check("ovf_t7", 32'(t), 32'd7);
        check("ovf_before", 32'(SC_OVF), 32'(1'b0));
        step();
        check("ovf_wrap_t", 32'(t), 32'd0);
        check("ovf_wrap", 32'(SC_OVF), 32'(OVF_EXP));
        SC_CLR = 1'b1;
        step();
        SC_CLR = 1'b0;
        check("ovf_clr_t", 32'(t), 32'd0);
        check("ovf_sticky", 32'(SC_OVF), 32'(OVF_EXP));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
